// File: rtl/mux_sel_arbiter.sv
// Round-robin owner of a shared 8:1 mux select; the last holder gets lowest priority on the next scan.
// Request to grant takes 1 cycle; grants end on release, request drop or hold limit, with back-to-back regrant.
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       release_vld,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic       busy,
  output logic       timeout
);

  localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    last, last_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    sel_nxt;
  logic [7:0]    grant_nxt;
  logic          busy_nxt;
  logic          timeout_nxt;

  logic          win_vld;
  logic [2:0]    win_idx;
  logic          hold_limit;
  logic          normal_end;

  // Scan downward in distance so the nearest requester after 'last' is the final assignment.
  always_comb begin
    logic [2:0] cand;
    win_vld = 1'b0;
    win_idx = 3'd0;
    cand    = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      cand = last + 3'(k);
      if (req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign hold_limit = (cnt == HOLD_LAST);
  assign normal_end = release_vld | ~req[sel];

  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    cnt_nxt     = cnt;
    sel_nxt     = sel;
    grant_nxt   = grant;
    busy_nxt    = busy;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = GRANT;
          last_nxt  = win_idx;
          cnt_nxt   = '0;
          sel_nxt   = win_idx;
          grant_nxt = 8'(1) << win_idx;
          busy_nxt  = 1'b1;
        end
      end
      GRANT: begin
        if (normal_end || hold_limit) begin
          timeout_nxt = hold_limit & ~normal_end;
          if (win_vld) begin
            last_nxt  = win_idx;
            cnt_nxt   = '0;
            sel_nxt   = win_idx;
            grant_nxt = 8'(1) << win_idx;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            sel_nxt   = 3'd0;
            grant_nxt = 8'h00;
            busy_nxt  = 1'b0;
          end
        end else if (!hold_limit) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        sel_nxt   = 3'd0;
        grant_nxt = 8'h00;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      last    <= 3'd7;
      cnt     <= '0;
      sel     <= 3'd0;
      grant   <= 8'h00;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      cnt     <= cnt_nxt;
      sel     <= sel_nxt;
      grant   <= grant_nxt;
      busy    <= busy_nxt;
      timeout <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed and randomized checks of mux_sel_arbiter against a cycle-counting round-robin model.
module tb_mux_sel_arbiter;

  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] req = 8'h00;
  logic       release_vld = 1'b0;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       busy;
  logic       timeout;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  mux_sel_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .release_vld(release_vld),
    .sel        (sel),
    .grant      (grant),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who holds the mux, for how many cycles so far, and who held it last.
  bit m_busy   = 1'b0;
  int m_holder = 0;
  int m_last   = 7;
  int m_held   = 0;
  bit m_to     = 1'b0;

  function automatic int pick(input logic [7:0] r, input int from);
    for (int k = 1; k <= 8; k++)
      if (r[(from + k) % 8]) return (from + k) % 8;
    return -1;
  endfunction

  int m_w;
  bit m_lim;
  bit m_nrm;
  always_comb begin
    m_w   = pick(req, m_busy ? m_holder : m_last);
    m_lim = m_busy && (m_held >= MAX_HOLD);
    m_nrm = m_busy && (release_vld || !req[m_holder]);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_holder <= 0; m_last <= 7; m_held <= 0; m_to <= 1'b0;
    end else if (!m_busy || m_lim || m_nrm) begin
      m_to <= m_lim && !m_nrm;
      if (m_w >= 0) begin
        m_busy <= 1'b1; m_holder <= m_w; m_last <= m_w; m_held <= 1;
      end else begin
        m_busy <= 1'b0; m_holder <= 0; m_held <= 0;
      end
    end else begin
      m_held <= m_held + 1;
      m_to   <= 1'b0;
    end
  end

  logic [7:0] exp_grant;
  logic [2:0] exp_sel;
  always_comb begin
    exp_grant = m_busy ? (8'(1) << m_holder) : 8'h00;
    exp_sel   = m_busy ? 3'(m_holder) : 3'd0;
  end

  always @(negedge clk) begin
    if (chk_en && !reset)
      chk("outputs{grant,sel,busy,timeout}", {18'd0, grant, sel, busy, timeout},
          {18'd0, exp_grant, exp_sel, m_busy, m_to});
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    req = 8'h00;
    release_vld = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("reset_grant", 32'(grant), 32'h00);
    chk("reset_sel", 32'(sel), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    // Idle with no requests
    repeat (5) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Single requester, then release
    req = 8'h01;
    @(negedge clk);
    chk("t2_grant", 32'(grant), 32'h01);
    chk("t2_sel", 32'(sel), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    release_vld = 1'b1;
    req = 8'h00;
    @(negedge clk);
    chk("t2_rel_grant", 32'(grant), 32'h00);
    chk("t2_rel_busy", 32'(busy), 32'd0);
    release_vld = 1'b0;

    // All requesting, release every second cycle: sel walks 0..7,0
    do_reset();
    req = 8'hFF;
    @(negedge clk);
    for (int k = 0; k <= 8; k++) begin
      chk("t3_sel_first", 32'(sel), 32'(k % 8));
      @(negedge clk);
      chk("t3_sel_second", 32'(sel), 32'(k % 8));
      release_vld = 1'b1;
      @(negedge clk);
      release_vld = 1'b0;
    end
    req = 8'h00;
    @(negedge clk);

    // Hold limit forces alternation between 2 and 5
    do_reset();
    req = 8'h24;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      chk("t4_sel2", 32'(sel), 32'd2);
      @(negedge clk);
    end
    chk("t4_sel5", 32'(sel), 32'd5);
    chk("t4_timeout", 32'(timeout), 32'd1);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      chk("t4_sel5_hold", 32'(sel), 32'd5);
      chk("t4_timeout_low", 32'(timeout), 32'd0);
    end
    @(negedge clk);
    chk("t4_sel2_back", 32'(sel), 32'd2);
    chk("t4_timeout2", 32'(timeout), 32'd1);
    req = 8'h00;
    @(negedge clk);

    // Holder drop, then release coinciding with the hold limit
    do_reset();
    req = 8'h48;
    @(negedge clk);
    chk("t5_sel3", 32'(sel), 32'd3);
    req = 8'h40;
    @(negedge clk);
    chk("t5_sel6", 32'(sel), 32'd6);
    chk("t5_drop_timeout", 32'(timeout), 32'd0);
    repeat (15) @(negedge clk);
    chk("t5_sel6_hold", 32'(sel), 32'd6);
    release_vld = 1'b1;
    @(negedge clk);
    chk("t5_both_timeout", 32'(timeout), 32'd0);
    chk("t5_regrant", 32'(grant), 32'h40);
    release_vld = 1'b0;
    req = 8'h00;
    @(negedge clk);

    // Asynchronous reset mid-grant
    do_reset();
    req = 8'h10;
    @(negedge clk);
    chk("t6_sel4", 32'(sel), 32'd4);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_grant", 32'(grant), 32'h00);
    chk("t6_async_sel", 32'(sel), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    chk("t6_async_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    req = 8'h90;
    @(negedge clk);
    chk("t6_restart_sel", 32'(sel), 32'd4);
    chk("t6_restart_grant", 32'(grant), 32'h10);

    // Randomized traffic; requests often held steady so hold limits are reached
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      case ($urandom_range(0, 9))
        0:       req = 8'h00;
        1:       req = 8'(1) << $urandom_range(0, 7);
        2, 3:    req = 8'($urandom);
        default: req = req;
      endcase
      release_vld = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
